// File: rtl/stack_pointer_unit_if.sv
// Operation/status bundle for the stack pointer unit.
// The master drives operations and observes the pointer state; the unit is the slave.
interface stack_pointer_unit_if #(
    parameter int WIDTH = 16
);
    logic             ena;
    logic             push;
    logic             pop;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
    logic             lerr;

    modport master (
        output ena, push, pop, load, d, clr_err,
        input  q, count, empty, full, ovf, unf, lerr
    );

    modport slave (
        input  ena, push, pop, load, d, clr_err,
        output q, count, empty, full, ovf, unf, lerr
    );
endinterface

// File: rtl/stack_pointer_unit.sv
// Downward-growing stack pointer with item count and sticky error flags.
// All state changes on the falling edge of clk; rst clears everything asynchronously.
module stack_pointer_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] BASE      = 16'h0400,
    parameter logic [WIDTH-1:0] LIMIT     = 16'h0200,
    parameter int               STEP_LOG2 = 1
) (
    input  logic               clk,
    input  logic               rst,
    stack_pointer_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] STEP       = ONE << STEP_LOG2;
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP - ONE;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_LERR,
        OP_PUSH,
        OP_OVF,
        OP_POP,
        OP_UNF
    } op_e;

    logic [WIDTH-1:0] q_r, q_n;
    logic [WIDTH-1:0] count_r, count_n;
    logic             ovf_r, ovf_n;
    logic             unf_r, unf_n;
    logic             lerr_r, lerr_n;

    logic             at_base;
    logic             at_limit;
    logic             load_ok;
    logic [WIDTH-1:0] load_count;
    op_e              op;

    assign at_base  = (q_r == BASE);
    assign at_limit = (q_r == LIMIT);

    // Legal load targets sit inside [LIMIT, BASE] on the same step grid as BASE.
    assign load_ok    = (bus.d >= LIMIT) && (bus.d <= BASE) &&
                        (((bus.d ^ BASE) & ALIGN_MASK) == '0);
    assign load_count = (BASE - bus.d) >> STEP_LOG2;

    always_comb begin
        op = OP_HOLD;
        if (bus.ena) begin
            if (bus.load) begin
                op = load_ok ? OP_LOAD : OP_LERR;
            end else if (bus.push && bus.pop) begin
                op = OP_HOLD;
            end else if (bus.push) begin
                op = at_limit ? OP_OVF : OP_PUSH;
            end else if (bus.pop) begin
                op = at_base ? OP_UNF : OP_POP;
            end
        end
    end

    always_comb begin
        q_n     = q_r;
        count_n = count_r;
        unique case (op)
            OP_LOAD: begin
                q_n     = bus.d;
                count_n = load_count;
            end
            OP_PUSH: begin
                q_n     = q_r - STEP;
                count_n = count_r + ONE;
            end
            OP_POP: begin
                q_n     = q_r + STEP;
                count_n = count_r - ONE;
            end
            default: ;
        endcase
    end

    // A flag raised on this edge survives a simultaneous clear.
    always_comb begin
        ovf_n  = (op == OP_OVF)  || (ovf_r  && !bus.clr_err);
        unf_n  = (op == OP_UNF)  || (unf_r  && !bus.clr_err);
        lerr_n = (op == OP_LERR) || (lerr_r && !bus.clr_err);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= BASE;
            count_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            lerr_r  <= 1'b0;
        end else begin
            q_r     <= q_n;
            count_r <= count_n;
            ovf_r   <= ovf_n;
            unf_r   <= unf_n;
            lerr_r  <= lerr_n;
        end
    end

    assign bus.q     = q_r;
    assign bus.count = count_r;
    assign bus.empty = at_base;
    assign bus.full  = at_limit;
    assign bus.ovf   = ovf_r;
    assign bus.unf   = unf_r;
    assign bus.lerr  = lerr_r;
endmodule

// File: doc/stack_pointer_unit.md
STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 Parameter WIDTH, default 16, width of pointer, data and count.
REQ-002 Parameter BASE, default 16'h0400, empty-stack pointer value (stack grows downward).
REQ-003 Parameter LIMIT, default 16'h0200, full-stack pointer value; BASE > LIMIT.
REQ-004 Parameter STEP_LOG2, default 1, log2 of bytes per push/pop (default step 2); (BASE-LIMIT) multiple of step.
REQ-005 CLK  in  1  single clock; all state updates on the falling edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 ENA  in  1  operation enable; when low, PUSH/POP/LOAD ignored.
REQ-008 PUSH  in  1  pre-decrement pointer by step.
REQ-009 POP  in  1  post-increment pointer by step.
REQ-010 LOAD  in  1  load pointer from D.
REQ-011 D  in  WIDTH  load value.
REQ-012 CLR_ERR  in  1  clears sticky error flags; not gated by ENA.
REQ-013 Q  out  WIDTH  current stack pointer (registered).
REQ-014 COUNT  out  WIDTH  number of stacked items (registered).
REQ-015 EMPTY  out  1  Q == BASE (combinational from Q).
REQ-016 FULL  out  1  Q == LIMIT (combinational from Q).
REQ-017 OVF, UNF, LERR  out  1 each  sticky push-overflow, pop-underflow, illegal-load flags.

Function
REQ-018 Per falling edge with ENA=1, priority: LOAD > (PUSH and POP both high) > PUSH > POP > hold.
REQ-019 PUSH, not FULL: Q <= Q - 2^STEP_LOG2, COUNT <= COUNT + 1, one-edge latency.
REQ-020 PUSH while FULL: Q and COUNT unchanged, OVF <= 1.
REQ-021 POP, not EMPTY: Q <= Q + 2^STEP_LOG2, COUNT <= COUNT - 1.
REQ-022 POP while EMPTY: Q and COUNT unchanged, UNF <= 1.
REQ-023 PUSH and POP same edge without LOAD: Q, COUNT and flags unchanged (net zero).
REQ-024 LOAD legal when LIMIT <= D <= BASE and D[STEP_LOG2-1:0] equals BASE[STEP_LOG2-1:0]: Q <= D, COUNT <= (BASE - D) >> STEP_LOG2.
REQ-025 LOAD illegal (outside range or misaligned): Q and COUNT unchanged, LERR <= 1; PUSH/POP that edge ignored.
REQ-026 ENA=0: Q and COUNT hold regardless of PUSH/POP/LOAD.
REQ-027 CLR_ERR=1: OVF, UNF, LERR <= 0, except a flag set by the same edge, which is set (set wins).
REQ-028 Pointer arithmetic never wraps: Q stays within [LIMIT, BASE] and COUNT within [0, (BASE-LIMIT)>>STEP_LOG2] at all times.
REQ-029 Invariant every cycle: COUNT == (BASE - Q) >> STEP_LOG2.

Reset
REQ-030 RST high: immediately, independent of CLK, Q <= BASE, COUNT <= 0, OVF = UNF = LERR = 0; thus EMPTY=1, FULL=0.
REQ-031 RST high overrides all inputs; operations resume on the first falling edge after RST deasserts.
REQ-032 RST asserted mid-operation (PUSH/LOAD active) aborts it; no partial update is retained.

Verification (defaults: BASE 0400, LIMIT 0200, step 2)
REQ-033 Reset then 3 PUSH edges -> Q 03FA, COUNT 3, EMPTY 0; then 3 POP -> Q 0400, COUNT 0, EMPTY 1.
REQ-034 256 PUSH edges -> Q 0200, COUNT 256 (0x0100), FULL 1; 257th PUSH -> Q 0200 held, OVF 1; CLR_ERR -> OVF 0.
REQ-035 POP on reset stack -> Q 0400, UNF 1; next edge CLR_ERR and POP together -> UNF remains 1.
REQ-036 LOAD D=0300 -> Q 0300, COUNT 128; LOAD D=0301 or D=0500 -> Q stays 0300, LERR 1; LOAD+PUSH same edge with D=0280 -> Q 0280, COUNT 192.
REQ-037 PUSH+POP same edge at Q 03FC -> Q 03FC; PUSH with ENA=0 -> no change, no flag.
REQ-038 Assert RST asynchronously between edges with Q 0300, OVF 1 -> Q 0400, COUNT 0, OVF 0 before next falling edge.
